// File: rtl/pill_filler_multi.sv
// Multi-lane pill bottle filler: counts hopper pulses per bottle, sequences bottles,
// and flags starvation, conveyor and emergency faults. Macro PILL_TOTAL_COUNT_EN adds total_pills.
module pill_filler_multi #(
    parameter int N_HOP        = 2,
    parameter int PILL_W       = 10,
    parameter int BOTTLE_W     = 7,
    parameter int TICK_DIV     = 1000,
    parameter int SWITCH_TICKS = 2,
    parameter int HOPPER_TICKS = 5
) (
    input  logic                         clk_1khz,
    input  logic                         clr,
    input  logic                         start,
    input  logic                         ack,
    input  logic                         emergency_stop,
    input  logic [N_HOP-1:0]             hopper_pulse,
    input  logic                         conveyor_ok,
    input  logic [PILL_W-1:0]            target_pills,
    input  logic [BOTTLE_W-1:0]          target_bottles,
    output logic [2:0]                   state,
    output logic [PILL_W-1:0]            now_pills,
    output logic [BOTTLE_W-1:0]          now_bottles,
    output logic [1:0]                   err_code,
    output logic [1:0]                   beep_mode,
    output logic                         start_chirp,
    output logic                         spill,
    output logic [PILL_W+BOTTLE_W-1:0]   total_pills
);
    typedef enum logic [2:0] {
        SETTING   = 3'd0,
        RUNNING   = 3'd1,
        SWITCHING = 3'd2,
        DONE      = 3'd3,
        ERROR     = 3'd4,
        FATAL     = 3'd5
    } state_t;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HT_W  = $clog2(HOPPER_TICKS + 2);
    localparam int ST_W  = $clog2(SWITCH_TICKS + 2);
    localparam int SUM_W = PILL_W + 3;

    state_t              state_q, state_d;
    logic [N_HOP-1:0]    hop_q, hop_d;
    logic [PILL_W-1:0]   pills_q, pills_d;
    logic [BOTTLE_W-1:0] bottles_q, bottles_d;
    logic [1:0]          err_q, err_d;
    logic                chirp_q, chirp_d;
    logic                spill_q, spill_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [HT_W-1:0]     htmr_q, htmr_d;
    logic [ST_W-1:0]     stmr_q, stmr_d;

    logic [N_HOP-1:0]    edges;
    logic [2:0]          k;
    logic [SUM_W-1:0]    sum;
    logic [BOTTLE_W-1:0] bottles_inc;
    logic                tick, h_expire, s_expire, hload, sload, enter_run;

    always_comb begin
        edges = hopper_pulse & ~hop_q;
        k     = '0;
        for (int unsigned i = 0; i < N_HOP; i++) begin
            k = k + 3'(edges[i]);
        end
    end

    // A timer "reaches 0" on the tick that takes it from 1 to 0, so the
    // transition lands exactly N*TICK_DIV cycles after the load.
    assign tick        = (pre_q == PRE_W'(TICK_DIV - 1));
    assign h_expire    = (htmr_q == '0) || (tick && htmr_q == HT_W'(1));
    assign s_expire    = (stmr_q == '0) || (tick && stmr_q == ST_W'(1));
    assign sum         = SUM_W'(pills_q) + SUM_W'(k);
    assign bottles_inc = bottles_q + BOTTLE_W'(1);

    always_comb begin
        state_d   = state_q;
        pills_d   = pills_q;
        bottles_d = bottles_q;
        err_d     = err_q;
        spill_d   = spill_q;
        hload     = 1'b0;
        if (emergency_stop) begin
            state_d = FATAL;
            err_d   = 2'd3;
        end else begin
            case (state_q)
                SETTING: begin
                    if (start && target_pills != '0 && target_bottles != '0) begin
                        state_d   = RUNNING;
                        pills_d   = '0;
                        bottles_d = '0;
                        err_d     = '0;
                        spill_d   = 1'b0;
                    end
                end
                RUNNING: begin
                    if (pills_q == target_pills) begin
                        bottles_d = bottles_inc;
                        state_d   = (bottles_inc == target_bottles) ? DONE : SWITCHING;
                    end else if (k != '0) begin
                        hload = 1'b1;
                        if (sum > SUM_W'(target_pills)) begin
                            pills_d = target_pills;
                            spill_d = 1'b1;
                        end else begin
                            pills_d = PILL_W'(sum);
                        end
                    end else if (h_expire) begin
                        state_d = ERROR;
                        err_d   = 2'd1;
                    end
                end
                SWITCHING: begin
                    if (s_expire) begin
                        if (conveyor_ok) begin
                            state_d = RUNNING;
                            pills_d = '0;
                        end else begin
                            state_d = ERROR;
                            err_d   = 2'd2;
                        end
                    end
                end
                ERROR: begin
                    if (err_q == 2'd1 && edges != '0) begin
                        state_d = RUNNING;
                        err_d   = '0;
                    end else if (err_q == 2'd2 && conveyor_ok) begin
                        state_d = RUNNING;
                        pills_d = '0;
                        err_d   = '0;
                    end
                end
                DONE:    if (ack) state_d = SETTING;
                FATAL:   if (ack) state_d = SETTING;
                default: state_d = SETTING;
            endcase
        end

        enter_run = (state_d == RUNNING) && (state_q != RUNNING);
        sload     = (state_d == SWITCHING) && (state_q != SWITCHING);
        hload     = hload | enter_run;
        chirp_d   = enter_run;
        hop_d     = hopper_pulse;

        pre_d  = (hload || sload || tick) ? '0 : pre_q + PRE_W'(1);
        htmr_d = hload ? HT_W'(HOPPER_TICKS)
               : (tick && htmr_q != '0) ? htmr_q - HT_W'(1) : htmr_q;
        stmr_d = sload ? ST_W'(SWITCH_TICKS)
               : (tick && stmr_q != '0) ? stmr_q - ST_W'(1) : stmr_q;
    end

    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            state_q   <= SETTING;
            hop_q     <= '0;
            pills_q   <= '0;
            bottles_q <= '0;
            err_q     <= '0;
            chirp_q   <= 1'b0;
            spill_q   <= 1'b0;
            pre_q     <= '0;
            htmr_q    <= '0;
            stmr_q    <= '0;
        end else begin
            state_q   <= state_d;
            hop_q     <= hop_d;
            pills_q   <= pills_d;
            bottles_q <= bottles_d;
            err_q     <= err_d;
            chirp_q   <= chirp_d;
            spill_q   <= spill_d;
            pre_q     <= pre_d;
            htmr_q    <= htmr_d;
            stmr_q    <= stmr_d;
        end
    end

`ifdef PILL_TOTAL_COUNT_EN
    localparam int TOT_W = PILL_W + BOTTLE_W;
    logic [TOT_W-1:0]  total_q, total_d;
    logic [PILL_W-1:0] added;

    // Pills only ever increase while RUNNING, so the delta is the counted amount.
    assign added   = (state_q == RUNNING) ? pills_d - pills_q : '0;
    assign total_d = total_q + TOT_W'(added);

    always_ff @(posedge clk_1khz) begin
        if (clr) total_q <= '0;
        else     total_q <= total_d;
    end
    assign total_pills = total_q;
`else
    assign total_pills = '0;
`endif

    always_comb begin
        case (state_q)
            DONE:    beep_mode = 2'd1;
            ERROR:   beep_mode = 2'd2;
            FATAL:   beep_mode = 2'd3;
            default: beep_mode = 2'd0;
        endcase
    end

    assign state       = state_q;
    assign now_pills   = pills_q;
    assign now_bottles = bottles_q;
    assign err_code    = err_q;
    assign start_chirp = chirp_q;
    assign spill       = spill_q;

endmodule

// File: tb/tb_pill_filler_multi.sv
// Scoreboard bench for pill_filler_multi: a deadline-based reference model queues
// the expected outputs per cycle and a monitor compares them after each edge.
module tb_pill_filler_multi;
    localparam int N_HOP        = 2;
    localparam int PILL_W       = 10;
    localparam int BOTTLE_W     = 7;
    localparam int TICK_DIV     = 4;
    localparam int SWITCH_TICKS = 2;
    localparam int HOPPER_TICKS = 5;
    localparam int TOT_W        = PILL_W + BOTTLE_W;

    localparam int S_SET = 0, S_RUN = 1, S_SW = 2, S_DONE = 3, S_ERR = 4, S_FAT = 5;

    logic                 clk = 1'b0;
    logic                 clr = 1'b1, start = 1'b0, ack = 1'b0, estop = 1'b0, conv = 1'b1;
    logic [N_HOP-1:0]     hp = '0;
    logic [PILL_W-1:0]    tp = '0;
    logic [BOTTLE_W-1:0]  tb = '0;
    logic [2:0]           state;
    logic [PILL_W-1:0]    now_pills;
    logic [BOTTLE_W-1:0]  now_bottles;
    logic [1:0]           err_code, beep_mode;
    logic                 start_chirp, spill;
    logic [TOT_W-1:0]     total_pills;

    pill_filler_multi #(
        .N_HOP(N_HOP), .PILL_W(PILL_W), .BOTTLE_W(BOTTLE_W), .TICK_DIV(TICK_DIV),
        .SWITCH_TICKS(SWITCH_TICKS), .HOPPER_TICKS(HOPPER_TICKS)
    ) dut (
        .clk_1khz(clk), .clr(clr), .start(start), .ack(ack), .emergency_stop(estop),
        .hopper_pulse(hp), .conveyor_ok(conv), .target_pills(tp), .target_bottles(tb),
        .state(state), .now_pills(now_pills), .now_bottles(now_bottles), .err_code(err_code),
        .beep_mode(beep_mode), .start_chirp(start_chirp), .spill(spill), .total_pills(total_pills)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int np; int nb; int ec; int bm; int sc; int sp; int tot;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic g_clr = 1'b1, g_estop = 1'b0, g_conv = 1'b1;
    logic [PILL_W-1:0]   nxt_tp = '0;
    logic [BOTTLE_W-1:0] nxt_tb = '0;

    // Reference model: timers are absolute deadlines in edge numbers.
    int m_st = S_SET, m_np = 0, m_nb = 0, m_ec = 0, m_sp = 0, m_sc = 0, m_tot = 0;
    int m_edge = 0, m_hop_dl = 0, m_sw_dl = 0;
    logic [N_HOP-1:0] m_prev = '0;

    task automatic model_step();
        logic [N_HOP-1:0] rise;
        int k, add, prev_st, bm;
        exp_t e;
        m_edge++;
        rise    = hp & ~m_prev;
        k       = int'(rise[0]) + int'(rise[1]);
        prev_st = m_st;
        m_prev  = clr ? '0 : hp;
        if (clr) begin
            m_st = S_SET; m_np = 0; m_nb = 0; m_ec = 0; m_sp = 0; m_tot = 0;
        end else if (estop) begin
            m_st = S_FAT; m_ec = 3;
        end else begin
            case (m_st)
                S_SET: if (start && tp != 0 && tb != 0) begin
                    m_st = S_RUN; m_np = 0; m_nb = 0; m_ec = 0; m_sp = 0;
                end
                S_RUN: begin
                    if (m_np == int'(tp)) begin
                        m_nb = (m_nb + 1) % (1 << BOTTLE_W);
                        m_st = (m_nb == int'(tb)) ? S_DONE : S_SW;
                    end else if (k > 0) begin
                        add = (m_np + k > int'(tp)) ? int'(tp) - m_np : k;
                        if (m_np + k > int'(tp)) m_sp = 1;
                        m_np  += add;
                        m_tot  = (m_tot + add) % (1 << TOT_W);
                        m_hop_dl = m_edge + HOPPER_TICKS * TICK_DIV;
                    end else if (m_edge >= m_hop_dl) begin
                        m_st = S_ERR; m_ec = 1;
                    end
                end
                S_SW: if (m_edge >= m_sw_dl) begin
                    if (conv) begin m_st = S_RUN; m_np = 0; end
                    else begin m_st = S_ERR; m_ec = 2; end
                end
                S_ERR: begin
                    if (m_ec == 1 && k > 0) begin m_st = S_RUN; m_ec = 0; end
                    else if (m_ec == 2 && conv) begin m_st = S_RUN; m_np = 0; m_ec = 0; end
                end
                S_DONE: if (ack) m_st = S_SET;
                S_FAT:  if (ack) m_st = S_SET;
                default: m_st = S_SET;
            endcase
        end
        m_sc = (!clr && m_st == S_RUN && prev_st != S_RUN) ? 1 : 0;
        if (m_sc == 1) m_hop_dl = m_edge + HOPPER_TICKS * TICK_DIV;
        if (m_st == S_SW && prev_st != S_SW) m_sw_dl = m_edge + SWITCH_TICKS * TICK_DIV;
        case (m_st)
            S_DONE:  bm = 1;
            S_ERR:   bm = 2;
            S_FAT:   bm = 3;
            default: bm = 0;
        endcase
        e.st = m_st; e.np = m_np; e.nb = m_nb; e.ec = m_ec; e.bm = bm; e.sc = m_sc; e.sp = m_sp;
`ifdef PILL_TOTAL_COUNT_EN
        e.tot = m_tot;
`else
        e.tot = 0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic s, input logic a, input logic [N_HOP-1:0] h, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clr = g_clr; estop = g_estop; conv = g_conv;
            tp = nxt_tp; tb = nxt_tb;
            start = s; ack = a; hp = h;
            model_step();
        end
    endtask

    task automatic pulse(input logic [N_HOP-1:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, m, 1);
            drive(1'b0, 1'b0, '0, 1);
        end
    endtask

    task automatic go(input int p, input int b);
        nxt_tp = PILL_W'(p);
        nxt_tb = BOTTLE_W'(b);
        drive(1'b0, 1'b0, '0, 1);
        drive(1'b1, 1'b0, '0, 1);
        drive(1'b0, 1'b0, '0, 1);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("state",       32'(state),       32'(e.st));
            chk("now_pills",   32'(now_pills),   32'(e.np));
            chk("now_bottles", 32'(now_bottles), 32'(e.nb));
            chk("err_code",    32'(err_code),    32'(e.ec));
            chk("beep_mode",   32'(beep_mode),   32'(e.bm));
            chk("start_chirp", 32'(start_chirp), 32'(e.sc));
            chk("spill",       32'(spill),       32'(e.sp));
            chk("total_pills", 32'(total_pills), 32'(e.tot));
        end
    end

    initial begin
        logic quiet;
        logic [N_HOP-1:0] h;
        quiet = 1'b0;

        g_clr = 1'b1;
        drive(1'b0, 1'b0, '0, 3);
        g_clr = 1'b0;

        // Normal fill, two bottles of three, single-lane pulses
        go(3, 2);
        pulse(2'b01, 3);
        drive(1'b0, 1'b0, '0, 12);
        pulse(2'b10, 3);
        drive(1'b0, 1'b0, '0, 3);
        drive(1'b0, 1'b1, '0, 1);
        drive(1'b0, 1'b0, '0, 2);

        // Simultaneous lanes overfill, then starvation and recovery
        go(3, 2);
        pulse(2'b11, 2);
        drive(1'b0, 1'b0, '0, 12);
        drive(1'b0, 1'b0, '0, 25);
        pulse(2'b01, 1);
        pulse(2'b01, 3);
        drive(1'b0, 1'b0, '0, 3);
        drive(1'b0, 1'b1, '0, 1);

        // Conveyor stopped at switch timeout
        go(2, 3);
        pulse(2'b01, 2);
        g_conv = 1'b0;
        drive(1'b0, 1'b0, '0, 14);
        g_conv = 1'b1;
        drive(1'b0, 1'b0, '0, 3);

        // Emergency stop during switching, ack held off by the stop
        pulse(2'b10, 2);
        drive(1'b0, 1'b0, '0, 3);
        g_estop = 1'b1;
        drive(1'b0, 1'b0, '0, 3);
        drive(1'b0, 1'b1, '0, 2);
        g_estop = 1'b0;
        drive(1'b0, 1'b0, '0, 2);
        drive(1'b0, 1'b1, '0, 1);
        drive(1'b0, 1'b0, '0, 2);

        // Two short batches feed the lifetime total, then clr mid-fill
        go(2, 1);
        pulse(2'b01, 2);
        drive(1'b0, 1'b0, '0, 2);
        drive(1'b0, 1'b1, '0, 1);
        go(2, 1);
        pulse(2'b11, 1);
        drive(1'b0, 1'b0, '0, 2);
        drive(1'b0, 1'b1, '0, 1);
        go(5, 2);
        pulse(2'b01, 2);
        g_clr = 1'b1;
        drive(1'b0, 1'b0, 2'b11, 1);
        g_clr = 1'b0;
        drive(1'b0, 1'b0, 2'b11, 1);
        drive(1'b0, 1'b0, '0, 2);

        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) quiet = ($urandom_range(0, 3) == 0);
            g_clr = ($urandom_range(0, 299) == 0);
            if (g_estop) g_estop = ($urandom_range(0, 3) != 0);
            else         g_estop = ($urandom_range(0, 249) == 0);
            g_conv = ($urandom_range(0, 7) != 0);
            if (m_st == S_SET) begin
                nxt_tp = PILL_W'($urandom_range(0, 6));
                nxt_tb = BOTTLE_W'($urandom_range(0, 3));
            end
            h = quiet ? '0 : N_HOP'($urandom_range(0, 3));
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, h, 1);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pill_filler_multi.md
PILL_FILLER_MULTI -- requirements
Module: pill_filler_multi

Interface
REQ-001 SHALL take parameter N_HOP, default 2, the number of hopper pulse lanes (1..4).
REQ-002 SHALL take parameter PILL_W, default 10, the pill-count width.
REQ-003 SHALL take parameter BOTTLE_W, default 7, the bottle-count width.
REQ-004 SHALL take parameter TICK_DIV, default 1000, the clk_1khz cycles per timer tick.
REQ-005 SHALL take parameter SWITCH_TICKS, default 2, the bottle-change dwell in ticks.
REQ-006 SHALL take parameter HOPPER_TICKS, default 5, the starvation timeout in ticks.
REQ-007 SHALL have port clk_1khz, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-008 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have ports start, ack and emergency_stop, inputs, 1 bit each, all level, already debounced.
REQ-010 SHALL have port hopper_pulse, input, N_HOP bits: one pill per rising edge per lane.
REQ-011 SHALL have port conveyor_ok, input, 1 bit: high when the conveyor is running.
REQ-012 SHALL have ports target_pills, input, PILL_W bits, and target_bottles, input, BOTTLE_W bits.
REQ-013 SHALL have port state, output, 3 bits: SETTING=0, RUNNING=1, SWITCHING=2, DONE=3, ERROR=4, FATAL=5.
REQ-014 SHALL have ports now_pills, output, PILL_W bits, and now_bottles, output, BOTTLE_W bits.
REQ-015 SHALL have port err_code, output, 2 bits: 0 none, 1 hopper starved, 2 conveyor stopped, 3 emergency.
REQ-016 SHALL have port beep_mode, output, 2 bits: 0 off, 1 continuous, 2 slow, 3 fast.
REQ-017 SHALL have port start_chirp, output, 1 bit: one-cycle pulse.
REQ-018 SHALL have port spill, output, 1 bit: sticky overfill flag.
REQ-019 SHALL have port total_pills, output, PILL_W+BOTTLE_W bits.

Function
REQ-020 SHALL detect a rising edge on each hopper lane by comparing it with a registered copy; k = number of lanes with an edge in the current cycle (0..N_HOP).
REQ-021 SHALL, in RUNNING, set now_pills to min(now_pills+k, target_pills) and set spill when now_pills+k > target_pills; the excess is discarded.
REQ-022 SHALL move SETTING->RUNNING on start when both targets are nonzero, clearing now_pills, now_bottles and err_code; start with either target zero is ignored.
REQ-023 SHALL, in RUNNING when now_pills==target_pills, increment now_bottles, then enter DONE if the new now_bottles==target_bottles, else SWITCHING.
REQ-024 SHALL, in RUNNING when the hopper timer reaches 0 with now_pills<target_pills, enter ERROR with err_code=1; the fill-complete check wins over timeout in the same cycle.
REQ-025 SHALL, in SWITCHING when the switch timer reaches 0, enter RUNNING with now_pills=0 if conveyor_ok is high, else enter ERROR with err_code=2.
REQ-026 SHALL, in ERROR with code 1, return to RUNNING on any hopper edge; that edge is not counted.
REQ-027 SHALL, in ERROR with code 2, return to RUNNING with now_pills=0 when conveyor_ok is high; err_code clears on leaving ERROR.
REQ-028 SHALL move DONE->SETTING on ack.
REQ-029 SHALL enter FATAL from any state while emergency_stop is high, setting err_code=3; this has priority over every other transition.
REQ-030 SHALL move FATAL->SETTING on ack with emergency_stop low.
REQ-031 SHALL use a prescaler that produces one tick every TICK_DIV cycles and restarts at 0 whenever a timer loads, so timeouts are exactly N*TICK_DIV cycles after load.
REQ-032 SHALL load the hopper timer with HOPPER_TICKS on entry to RUNNING and on every hopper edge while in RUNNING.
REQ-033 SHALL load the switch timer with SWITCH_TICKS on entry to SWITCHING; both timers decrement on each tick and hold at 0.
REQ-034 SHALL drive beep_mode as 1 in DONE, 2 in ERROR, 3 in FATAL and 0 otherwise, decoded from registered state.
REQ-035 SHALL pulse start_chirp for one cycle on every entry to RUNNING.

Reset
REQ-036 SHALL, while clr is high at a clock edge, force state=SETTING, zero all counters, timers, prescaler and edge registers, and set err_code=0, spill=0, start_chirp=0 and total_pills=0.
REQ-037 SHALL apply clr mid-fill immediately; no pill edge is counted in the clr cycle or the cycle after it.
REQ-038 SHALL clear spill on clr and on the SETTING->RUNNING transition only.

Configuration
REQ-039 SHALL implement total_pills only when macro PILL_TOTAL_COUNT_EN is defined.
REQ-040 With PILL_TOTAL_COUNT_EN defined, total_pills SHALL add every counted pill, is not cleared by SETTING, and wraps modulo 2^(PILL_W+BOTTLE_W).
REQ-041 Without PILL_TOTAL_COUNT_EN, total_pills SHALL be tied to 0 and no accumulator SHALL exist.

Verification (TICK_DIV=4, N_HOP=2)
REQ-042 SHALL cover normal fill: targets 3/2 with single-lane edges -> RUNNING, SWITCHING for 8 cycles, RUNNING, then DONE with now_bottles=2 and beep_mode=1.
REQ-043 SHALL cover simultaneous edges: target 3 with both lanes edging twice -> now_pills=3, spill=1, then SWITCHING.
REQ-044 SHALL cover starvation: no edges for 20 cycles in RUNNING -> ERROR with err_code=1; one edge -> RUNNING with now_pills unchanged.
REQ-045 SHALL cover conveyor fault: conveyor_ok=0 at switch timeout -> ERROR with err_code=2; conveyor_ok=1 -> RUNNING with now_pills=0.
REQ-046 SHALL cover emergency stop: emergency_stop in SWITCHING -> FATAL with beep_mode=3; ack while the stop is held -> stays FATAL; release then ack -> SETTING.
REQ-047 SHALL cover reset: clr mid-fill -> all outputs zero; with PILL_TOTAL_COUNT_EN, total_pills keeps counting across two batches.
